counterdiv_prog: RTL and testbench
==================================

# counterdiv_prog

Multi-channel, runtime-programmable counter/clock divider producing per-channel tick pulses and square-wave outputs. Each channel holds its own divisor and mode (periodic tick, one-shot, square), loaded through a shared write port. It is the parametrised successor to the fixed-count divider and drives game-step timers, VGA sub-rate strobes and debounce samplers from one `clk` domain.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `WIDTH`, 16: divisor and counter width in bits.
- `RESET_DIV`, 2: divisor loaded into every channel at reset (must fit in `WIDTH`).
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  global count enable.
- `ch_en`  in  CHANNELS  per-channel count enable.
- `load`  in  1  one-cycle write strobe for the channel config.
- `load_ch`  in  max(1,$clog2(CHANNELS))  channel index for the write.
- `load_div`  in  WIDTH  divisor D to write.
- `load_mode`  in  2  00 periodic, 01 one-shot, 10 square, 11 reserved (treated as periodic).
- `start`  in  CHANNELS  one-shot arm pulse per channel.
- `tick`  out  CHANNELS  registered one-cycle terminal-count pulse.
- `sq`  out  CHANNELS  registered square output (square mode only; 0 in other modes).
- `busy`  out  CHANNELS  one-shot armed and counting.

## Operation
- Per-channel state: `div[WIDTH]`, `mode[2]`, `count[WIDTH]`, `tick`, `sq`, `busy`.
- Reset (async, any time): `div`=RESET_DIV, `mode`=periodic, `count`=0, `tick`=0, `sq`=0, `busy`=0 on all channels. Reset mid-count discards progress; no tick is emitted.
- Channel "advances" on a cycle when `en` & `ch_en[i]` & `div`≠0 & (mode≠one-shot | `busy`).
- On an advancing cycle: if `count`==`div`-1 -> `count`<=0, `tick`<=1 (terminal); else `count`<=`count`+1, `tick`<=0.
- Non-advancing cycle: `count`, `sq`, `busy` hold; `tick`<=0.
- Period is exactly D advancing cycles (no off-by-one). D=1: `tick` high every advancing cycle. D=0: channel disabled, never ticks.
- Periodic: counts continuously; terminal -> tick.
- Square: terminal also toggles `sq`; period 2·D advancing cycles, 50% duty.
- One-shot: idle (`busy`=0, `count`=0) until `start[i]`; then `busy`<=1, `count`<=0. After D advancing cycles: `tick`<=1, `busy`<=0, `count`<=0. `start` while busy restarts from `count`=0 with no tick. `start` in other modes is ignored.
- Load: when `load` and `load_ch`<CHANNELS, target channel gets `div`<=`load_div`, `mode`<=`load_mode`, `count`<=0, `sq`<=0, `busy`<=0, `tick`<=0. Out-of-range `load_ch` ignored. Other channels unaffected.
- Priority on one channel same cycle: load > start > terminal count. Load coinciding with terminal: no tick. Load with start on same channel: start ignored.
- `count` compare uses `div`-1 computed in WIDTH bits; `count` never exceeds `div`-1 because load clears it.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- `tick` is high in the cycle after the terminal advancing edge, exactly one cycle (unless the next cycle is also terminal, e.g. D=1).
- Load takes effect at the load edge; first tick after load with continuous enable appears D cycles after the load edge.
- One-shot: `start` at edge 0 -> `busy` high from cycle 1; `tick` high in cycle D+1 (continuous enable), coinciding with `busy` falling.
- `en` or `ch_en` low stretches the period by the number of non-advancing cycles; `tick` never asserted while stalled.

## Test plan
- Reset, all enables high, no loads -> every channel ticks every 2 cycles; `sq`=0; `busy`=0; assert async reset mid-period -> all outputs 0 within the same cycle.
- Load ch1 D=5 periodic, enables high -> ticks at cycles 5,10,15 after load; ch0 keeps period 2; load D=1 -> `tick[1]` constantly high; D=0 -> never ticks.
- Load ch2 D=3 square -> `sq[2]` toggles every 3 cycles (period 6), `tick[2]` coincident with each toggle.
- Load ch3 D=4 one-shot, pulse `start[3]` -> `busy` 4 cycles, single `tick` in cycle 5, then idle; re-pulse `start[3]` at count 2 -> tick 4 cycles after restart, none earlier.
- Toggle `en` low for 3 cycles during D=5 periodic -> period stretches to 8; `tick` 0 while stalled; `ch_en[i]` low stalls only channel i.
- Load on the terminal cycle of ch0 -> no tick, count restarts; `load_ch`=CHANNELS (non-power-of-2 config, CHANNELS=3) -> no channel changes.

Source files
------------

// File: rtl/counterdiv_prog_if.sv
// Control/status bundle of the programmable divider: config write port, enables, arm pulses and
// per-channel tick/square/busy outputs. The master drives control, the slave (divider) drives status.
interface counterdiv_prog_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                en;
    logic [CHANNELS-1:0] ch_en;
    logic                load;
    logic [CW-1:0]       load_ch;
    logic [WIDTH-1:0]    load_div;
    logic [1:0]          load_mode;
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] sq;
    logic [CHANNELS-1:0] busy;

    modport master (
        output en, ch_en, load, load_ch, load_div, load_mode, start,
        input  tick, sq, busy
    );

    modport slave (
        input  en, ch_en, load, load_ch, load_div, load_mode, start,
        output tick, sq, busy
    );
endinterface

// File: rtl/counterdiv_prog.sv
// Multi-channel programmable divider: periodic tick, one-shot or square wave per channel.
// All outputs registered (one edge after the terminal advancing edge); no backpressure, stalls via en/ch_en.
module counterdiv_prog #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    counterdiv_prog_if.slave bus
);
    localparam logic [1:0] MODE_PERIODIC = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_SQUARE   = 2'b10;

    logic [WIDTH-1:0]    r_div   [CHANNELS];
    logic [WIDTH-1:0]    r_count [CHANNELS];
    logic [1:0]          r_mode  [CHANNELS];
    logic [CHANNELS-1:0] r_tick;
    logic [CHANNELS-1:0] r_sq;
    logic [CHANNELS-1:0] r_busy;

    logic [CHANNELS-1:0] w_load_hit;
    logic [CHANNELS-1:0] w_start_hit;
    logic [CHANNELS-1:0] w_advance;
    logic [CHANNELS-1:0] w_terminal;

    // An out-of-range load_ch matches no channel index, so such writes fall away naturally.
    always_comb begin
        w_load_hit  = '0;
        w_start_hit = '0;
        w_advance   = '0;
        w_terminal  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_load_hit[i]  = bus.load && (int'(bus.load_ch) == i);
            w_start_hit[i] = bus.start[i] && (r_mode[i] == MODE_ONESHOT);
            w_advance[i]   = bus.en && bus.ch_en[i] && (r_div[i] != '0) &&
                             ((r_mode[i] != MODE_ONESHOT) || r_busy[i]);
            w_terminal[i]  = (r_count[i] == (r_div[i] - WIDTH'(1)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_div[i]   <= WIDTH'(RESET_DIV);
                r_mode[i]  <= MODE_PERIODIC;
                r_count[i] <= '0;
            end
            r_tick <= '0;
            r_sq   <= '0;
            r_busy <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_load_hit[i]) begin
                    r_div[i]   <= bus.load_div;
                    r_mode[i]  <= bus.load_mode;
                    r_count[i] <= '0;
                    r_sq[i]    <= 1'b0;
                    r_busy[i]  <= 1'b0;
                    r_tick[i]  <= 1'b0;
                end else if (w_start_hit[i]) begin
                    // Arming (or re-arming) restarts the count and never ticks this edge.
                    r_busy[i]  <= 1'b1;
                    r_count[i] <= '0;
                    r_tick[i]  <= 1'b0;
                end else if (w_advance[i] && w_terminal[i]) begin
                    r_count[i] <= '0;
                    r_tick[i]  <= 1'b1;
                    if (r_mode[i] == MODE_SQUARE) begin
                        r_sq[i] <= ~r_sq[i];
                    end
                    if (r_mode[i] == MODE_ONESHOT) begin
                        r_busy[i] <= 1'b0;
                    end
                end else if (w_advance[i]) begin
                    r_count[i] <= r_count[i] + WIDTH'(1);
                    r_tick[i]  <= 1'b0;
                end else begin
                    r_tick[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.tick = r_tick;
    assign bus.sq   = r_sq;
    assign bus.busy = r_busy;
endmodule

// File: tb/tb_counterdiv_prog.sv
// Directed bench for counterdiv_prog: a 4-channel instance driven from a vector table plus
// corner sequences, and a 3-channel instance for the out-of-range channel write.
module tb_counterdiv_prog;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    counterdiv_prog_if #(.CHANNELS(4), .WIDTH(16)) bus_a ();
    counterdiv_prog_if #(.CHANNELS(3), .WIDTH(16)) bus_b ();

    counterdiv_prog #(.CHANNELS(4), .WIDTH(16), .RESET_DIV(2)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    counterdiv_prog #(.CHANNELS(3), .WIDTH(16), .RESET_DIV(2)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    typedef struct {
        logic        load;
        logic [1:0]  lch;
        logic [15:0] ldiv;
        logic [1:0]  lmode;
        logic [3:0]  start;
        logic [3:0]  tick;
        logic [3:0]  sq;
        logic [3:0]  busy;
    } vec_t;

    vec_t tbl [36];
    int   checks;
    int   errors;

    function automatic vec_t mk(input logic ld, input logic [1:0] ch, input logic [15:0] dv,
                                input logic [1:0] md, input logic [3:0] st, input logic [3:0] tk,
                                input logic [3:0] s, input logic [3:0] b);
        vec_t v;
        v.load  = ld;
        v.lch   = ch;
        v.ldiv  = dv;
        v.lmode = md;
        v.start = st;
        v.tick  = tk;
        v.sq    = s;
        v.busy  = b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic ld, input logic [1:0] ch, input logic [15:0] dv,
                           input logic [1:0] md, input logic [3:0] st);
        bus_a.load      = ld;
        bus_a.load_ch   = ch;
        bus_a.load_div  = dv;
        bus_a.load_mode = md;
        bus_a.start     = st;
    endtask

    task automatic idle_a();
        drive_a(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        bus_a.en    = 1'b0;
        bus_a.ch_en = 4'h0;
        idle_a();
        bus_b.en        = 1'b0;
        bus_b.ch_en     = 3'b000;
        bus_b.load      = 1'b0;
        bus_b.load_ch   = 2'd0;
        bus_b.load_div  = 16'd0;
        bus_b.load_mode = 2'b00;
        bus_b.start     = 3'b000;

        // load, ch, div, mode, start | tick, sq, busy (one edge per row, all enables high)
        tbl[0]  = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[1]  = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        tbl[2]  = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[3]  = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        tbl[4]  = mk(1'b1, 2'd1, 16'd5, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[5]  = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1101, 4'b0000, 4'b0000);
        tbl[6]  = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[7]  = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1101, 4'b0000, 4'b0000);
        tbl[8]  = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[9]  = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        tbl[10] = mk(1'b1, 2'd2, 16'd3, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[11] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
        tbl[12] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[13] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1101, 4'b0100, 4'b0000);
        tbl[14] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0010, 4'b0100, 4'b0000);
        tbl[15] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1001, 4'b0100, 4'b0000);
        tbl[16] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        tbl[17] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
        tbl[18] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[19] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1111, 4'b0100, 4'b0000);
        tbl[20] = mk(1'b1, 2'd3, 16'd4, 2'b01, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        tbl[21] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b1000, 4'b0001, 4'b0100, 4'b1000);
        tbl[22] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0100, 4'b0000, 4'b1000);
        tbl[23] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0001, 4'b0000, 4'b1000);
        tbl[24] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0010, 4'b0000, 4'b1000);
        tbl[25] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b1101, 4'b0100, 4'b0000);
        tbl[26] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        tbl[27] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0001, 4'b0100, 4'b0000);
        tbl[28] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b1000, 4'b0100, 4'b0000, 4'b1000);
        tbl[29] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0011, 4'b0000, 4'b1000);
        tbl[30] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        tbl[31] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b1000, 4'b0101, 4'b0100, 4'b1000);
        tbl[32] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0000, 4'b0100, 4'b1000);
        tbl[33] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0001, 4'b0100, 4'b1000);
        tbl[34] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000, 4'b0110, 4'b0000, 4'b1000);
        tbl[35] = mk(1'b0, 2'd0, 16'd0, 2'b00, 4'b0001, 4'b1001, 4'b0000, 4'b0000);

        step();
        step();
        chk("reset_a tick", 32'(bus_a.tick), 32'd0);
        chk("reset_a sq",   32'(bus_a.sq),   32'd0);
        chk("reset_a busy", 32'(bus_a.busy), 32'd0);
        chk("reset_b tick", 32'(bus_b.tick), 32'd0);
        chk("reset_b sq",   32'(bus_b.sq),   32'd0);
        chk("reset_b busy", 32'(bus_b.busy), 32'd0);

        rst_a       = 1'b0;
        bus_a.en    = 1'b1;
        bus_a.ch_en = 4'hF;
        for (int i = 0; i < 36; i++) begin
            drive_a(tbl[i].load, tbl[i].lch, tbl[i].ldiv, tbl[i].lmode, tbl[i].start);
            step();
            chk($sformatf("vec%0d tick", i), 32'(bus_a.tick), 32'(tbl[i].tick));
            chk($sformatf("vec%0d sq", i),   32'(bus_a.sq),   32'(tbl[i].sq));
            chk($sformatf("vec%0d busy", i), 32'(bus_a.busy), 32'(tbl[i].busy));
        end
        idle_a();

        // D=1 ticks every cycle, D=0 never ticks
        drive_a(1'b1, 2'd1, 16'd1, 2'b00, 4'b0000);
        step();
        chk("d1 load edge", 32'(bus_a.tick[1]), 32'd0);
        idle_a();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("d1 k%0d", k), 32'(bus_a.tick[1]), 32'd1);
        end
        drive_a(1'b1, 2'd1, 16'd0, 2'b00, 4'b0000);
        step();
        chk("d0 load edge", 32'(bus_a.tick[1]), 32'd0);
        idle_a();
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("d0 k%0d", k), 32'(bus_a.tick[1]), 32'd0);
        end

        // Global enable low for 3 edges stretches a D=5 period to 8
        drive_a(1'b1, 2'd0, 16'd2, 2'b00, 4'b0000);
        step();
        drive_a(1'b1, 2'd1, 16'd5, 2'b00, 4'b0000);
        step();
        idle_a();
        for (int k = 1; k <= 12; k++) begin
            bus_a.en = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            step();
            chk($sformatf("en_stall t1 k%0d", k), 32'(bus_a.tick[1]), 32'(k == 8));
            if (k >= 3 && k <= 5) begin
                chk($sformatf("en_stall all k%0d", k), 32'(bus_a.tick), 32'd0);
            end
        end
        bus_a.en = 1'b1;

        // ch_en[1] low stalls only channel 1
        drive_a(1'b1, 2'd0, 16'd2, 2'b00, 4'b0000);
        step();
        drive_a(1'b1, 2'd1, 16'd5, 2'b00, 4'b0000);
        step();
        idle_a();
        for (int k = 1; k <= 12; k++) begin
            bus_a.ch_en = (k >= 3 && k <= 5) ? 4'b1101 : 4'b1111;
            step();
            chk($sformatf("chen t1 k%0d", k), 32'(bus_a.tick[1]), 32'(k == 8));
            chk($sformatf("chen t0 k%0d", k), 32'(bus_a.tick[0]), 32'(k % 2 == 1));
        end
        bus_a.ch_en = 4'hF;

        // Next edge is ch0's terminal; a load there suppresses the tick and restarts the count
        drive_a(1'b1, 2'd0, 16'd3, 2'b00, 4'b0000);
        step();
        chk("load_on_terminal", 32'(bus_a.tick[0]), 32'd0);
        idle_a();
        for (int j = 1; j <= 6; j++) begin
            step();
            chk($sformatf("after_term_load j%0d", j), 32'(bus_a.tick[0]), 32'(j % 3 == 0));
        end

        // Load with start on the same channel: start is ignored
        drive_a(1'b1, 2'd3, 16'd2, 2'b01, 4'b1000);
        step();
        chk("load_start busy", 32'(bus_a.busy[3]), 32'd0);
        idle_a();
        step();
        chk("load_start busy2", 32'(bus_a.busy[3]), 32'd0);
        chk("load_start tick2", 32'(bus_a.tick[3]), 32'd0);
        drive_a(1'b0, 2'd0, 16'd0, 2'b00, 4'b1000);
        step();
        chk("os2 armed", 32'(bus_a.busy[3]), 32'd1);
        idle_a();
        step();
        chk("os2 busy", 32'(bus_a.busy[3]), 32'd1);
        chk("os2 no tick", 32'(bus_a.tick[3]), 32'd0);
        step();
        chk("os2 tick", 32'(bus_a.tick[3]), 32'd1);
        chk("os2 done", 32'(bus_a.busy[3]), 32'd0);

        // Asynchronous reset mid-count clears outputs before the next edge
        drive_a(1'b0, 2'd0, 16'd0, 2'b00, 4'b1000);
        step();
        chk("pre_reset busy", 32'(bus_a.busy[3]), 32'd1);
        idle_a();
        #2;
        rst_a = 1'b1;
        #1;
        chk("async_reset tick", 32'(bus_a.tick), 32'd0);
        chk("async_reset sq",   32'(bus_a.sq),   32'd0);
        chk("async_reset busy", 32'(bus_a.busy), 32'd0);
        #2;
        rst_a = 1'b0;
        step();
        chk("post_reset k1", 32'(bus_a.tick), 32'd0);
        step();
        chk("post_reset k2", 32'(bus_a.tick), 32'hF);
        chk("post_reset busy", 32'(bus_a.busy), 32'd0);

        // Three-channel instance: load_ch=3 must touch nothing
        bus_b.en    = 1'b1;
        bus_b.ch_en = 3'b111;
        step();
        rst_b           = 1'b0;
        bus_b.load      = 1'b1;
        bus_b.load_ch   = 2'd3;
        bus_b.load_div  = 16'd5;
        bus_b.load_mode = 2'b10;
        step();
        chk("oob k1 tick", 32'(bus_b.tick), 32'd0);
        bus_b.load = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            step();
            chk($sformatf("oob k%0d tick", k), 32'(bus_b.tick), (k % 2 == 0) ? 32'h7 : 32'h0);
            chk($sformatf("oob k%0d sq", k),   32'(bus_b.sq),   32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
